// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selector and load-use / retire-wait hazard detector for an
// in-order pipeline that tracks DEPTH in-flight destination writes.
module fwd_hazard_unit #(
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [AW-1:0]                issue_rd,
    input  logic                         issue_reg_write,
    input  logic                         issue_is_load,
    input  logic [NSRC*AW-1:0]           src_addr,
    input  logic [NSRC-1:0]              src_used,
    input  logic                         flush,
    output logic [NSRC*(DEPTH+1)-1:0]    fwd_sel,
    output logic                         stall,
    output logic [31:0]                  stall_cnt
);

    localparam int SW = DEPTH + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wr_q, wr_d;
    logic [DEPTH-1:0] ld_q, ld_d;
    logic [AW-1:0]    rd_q [DEPTH];
    logic [AW-1:0]    rd_d [DEPTH];
    logic [31:0]      stall_cnt_q;
    logic [NSRC-1:0]  op_hazard;
    logic             hazard;

    genvar gi, gk;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_op
            logic [AW-1:0]    addr;
            logic [DEPTH-1:0] match;
            logic [SW-1:0]    sel;
            logic             hz;

            assign addr = src_addr[gi*AW +: AW];

            for (gk = 0; gk < DEPTH; gk++) begin : g_ent
                assign match[gk] = valid_q[gk] && wr_q[gk] && src_used[gi]
                                   && (rd_q[gk] == addr) && (rd_q[gk] != '0);
            end

            // Scan oldest to youngest so the youngest match overwrites the rest.
            always_comb begin
                sel = SW'(1);
                hz  = 1'b0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (match[k]) begin
                        sel        = '0;
                        sel[k + 1] = 1'b1;
                        hz         = ld_q[k] && (k < LOAD_LAT);
                    end
                end
                if (FWD_EN == 0) begin
                    sel = SW'(1);
                    hz  = |match;
                end
            end

            assign fwd_sel[gi*SW +: SW] = sel;
            assign op_hazard[gi]        = hz;
        end
    endgenerate

    // A flush kills whatever the hazard was waiting on, so it never stalls.
    assign hazard      = (|op_hazard) && !flush;
    assign issue_ready = !hazard;
    assign stall       = issue_valid && hazard;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        valid_d    = '0;
        wr_d       = '0;
        ld_d       = '0;
        valid_d[0] = issue_valid && issue_ready && !flush;
        wr_d[0]    = issue_reg_write;
        ld_d[0]    = issue_is_load;
        rd_d[0]    = issue_rd;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1] && !flush;
            wr_d[k]    = wr_q[k-1];
            ld_d[k]    = ld_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    // Payload needs no reset: every use is qualified by the valid bit.
    always_ff @(posedge clk) begin
        wr_q <= wr_d;
        ld_q <= ld_d;
        rd_q <= rd_d;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, corner sequences and random
// traffic checked against an age-based in-flight instruction model.
module tb_fwd_hazard_unit;

    localparam int AW       = 5;
    localparam int NSRC     = 2;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int SW       = DEPTH + 1;

    logic        clk = 1'b0;
    logic        rst_n, issue_valid, issue_reg_write, issue_is_load, flush;
    logic [4:0]  issue_rd;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic        rdy1, stl1, rdy0, stl0;
    logic [7:0]  sel1, sel0;
    logic [31:0] cnt1, cnt0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(rdy1),
        .issue_rd(issue_rd), .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load),
        .src_addr(src_addr), .src_used(src_used), .flush(flush),
        .fwd_sel(sel1), .stall(stl1), .stall_cnt(cnt1)
    );

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(rdy0),
        .issue_rd(issue_rd), .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load),
        .src_addr(src_addr), .src_used(src_used), .flush(flush),
        .fwd_sel(sel0), .stall(stl0), .stall_cnt(cnt0)
    );

    // Model: instructions in flight with their age in cycles since issue (0 = EX).
    typedef struct { int rd; bit wr; bit ld; int age; } inflight_t;
    typedef inflight_t ifq_t[$];
    ifq_t mq0, mq1;
    logic [31:0] mcnt [2];

    logic [7:0]  a_sel [2];
    logic        a_stl [2];
    logic        a_rdy [2];
    logic [31:0] a_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic v; logic [4:0] rd; logic wr; logic ld;
        logic [4:0] s0; logic [4:0] s1; logic [1:0] u; logic fl;
        logic [3:0] e0; logic [3:0] e1; logic est; logic erdy; logic [31:0] ecnt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(int v, int rd, int wr, int ld, int s0, int s1, int u, int fl,
                                int e0, int e1, int est, int erdy, int ecnt);
        vec_t r;
        r.v = 1'(v); r.rd = 5'(rd); r.wr = 1'(wr); r.ld = 1'(ld);
        r.s0 = 5'(s0); r.s1 = 5'(s1); r.u = 2'(u); r.fl = 1'(fl);
        r.e0 = 4'(e0); r.e1 = 4'(e1); r.est = 1'(est); r.erdy = 1'(erdy); r.ecnt = 32'(ecnt);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int v, input int rd, input int wr, input int ld,
                         input int s0, input int s1, input int u, input int fl);
        issue_valid     = 1'(v);
        issue_rd        = 5'(rd);
        issue_reg_write = 1'(wr);
        issue_is_load   = 1'(ld);
        src_addr        = {5'(s1), 5'(s0)};
        src_used        = 2'(u);
        flush           = 1'(fl);
    endtask

    function automatic void model_eval(input int m, output logic [7:0] sel, output logic hz);
        ifq_t q;
        int best;
        logic [4:0] a;
        if (m == 1) q = mq1; else q = mq0;
        sel = '0;
        hz  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            best = -1;
            a = src_addr[i*AW +: AW];
            for (int j = 0; j < q.size(); j++) begin
                if (src_used[i] && q[j].wr && a != 5'd0 && q[j].rd == int'(a)
                    && (best < 0 || q[j].age < q[best].age)) best = j;
            end
            if (best < 0) begin
                sel[i*SW +: SW] = 4'b0001;
            end else if (m == 1) begin
                sel[i*SW +: SW] = 4'(1 << (q[best].age + 1));
                if (q[best].ld && q[best].age < LOAD_LAT) hz = 1'b1;
            end else begin
                sel[i*SW +: SW] = 4'b0001;
                hz = 1'b1;
            end
        end
    endfunction

    task automatic model_step(input int m, input logic st, input logic rdy);
        ifq_t q, nq;
        inflight_t e;
        if (m == 1) q = mq1; else q = mq0;
        if (!rst_n) begin
            q = {};
            mcnt[m] = 32'd0;
        end else begin
            if (st && mcnt[m] != 32'hFFFF_FFFF) mcnt[m] = mcnt[m] + 32'd1;
            nq = {};
            if (!flush) begin
                foreach (q[j]) begin
                    if (q[j].age + 1 < DEPTH) begin
                        e = q[j];
                        e.age = e.age + 1;
                        nq.push_back(e);
                    end
                end
                if (issue_valid && rdy) begin
                    e.rd = int'(issue_rd); e.wr = issue_reg_write; e.ld = issue_is_load; e.age = 0;
                    nq.push_back(e);
                end
            end
            q = nq;
        end
        if (m == 1) mq1 = q; else mq0 = q;
    endtask

    // One clock: sample and check at the falling edge, advance the model at the rising edge.
    task automatic tick(input bit check_en);
        logic [7:0] es [2];
        logic eh [2], est [2], erdy [2];
        @(negedge clk);
        a_sel[1] = sel1; a_stl[1] = stl1; a_rdy[1] = rdy1; a_cnt[1] = cnt1;
        a_sel[0] = sel0; a_stl[0] = stl0; a_rdy[0] = rdy0; a_cnt[0] = cnt0;
        for (int m = 0; m < 2; m++) begin
            model_eval(m, es[m], eh[m]);
            eh[m]   = eh[m] && !flush;
            erdy[m] = !eh[m];
            est[m]  = issue_valid && eh[m];
            if (check_en) begin
                chk($sformatf("f%0d_fwd_sel", m), 32'(a_sel[m]), 32'(es[m]));
                chk($sformatf("f%0d_stall", m), 32'(a_stl[m]), 32'(est[m]));
                chk($sformatf("f%0d_ready", m), 32'(a_rdy[m]), 32'(erdy[m]));
                chk($sformatf("f%0d_stall_cnt", m), a_cnt[m], mcnt[m]);
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m, est[m], erdy[m]);
        #1;
    endtask

    initial begin
        int n;
        mcnt[0] = 32'd0;
        mcnt[1] = 32'd0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        tick(1);
        rst_n = 1'b1;
        chk("reset_fwd_sel", 32'(a_sel[1]), 32'h11);
        chk("reset_stall", 32'(a_stl[1]), 32'd0);
        chk("reset_ready", 32'(a_rdy[1]), 32'd1);
        chk("reset_cnt", a_cnt[1], 32'd0);
        chk("reset_fwd_sel_nofwd", 32'(a_sel[0]), 32'h11);

        //              v rd wr ld s0 s1 u fl  e0 e1 st rdy cnt
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));  // add r3
        tbl.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 2, 1, 0, 1, 0));  // use r3, distance 1
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 2, 0, 1, 4, 0, 1, 0));  // distance 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 2, 0, 1, 8, 0, 1, 0));  // distance 3
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 2, 0, 1, 1, 0, 1, 0));  // distance 4: retired
        tbl.push_back(mk(1, 5, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0));  // lw r5
        tbl.push_back(mk(1, 0, 0, 0, 5, 0, 1, 0, 2, 1, 1, 0, 0));  // load-use stall
        tbl.push_back(mk(1, 0, 0, 0, 5, 0, 1, 0, 4, 1, 0, 1, 1));  // forwarded from MEM
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1));  // add r4
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1));  // add r4
        tbl.push_back(mk(1, 0, 0, 0, 4, 4, 3, 0, 2, 2, 0, 1, 1));  // youngest wins
        tbl.push_back(mk(1, 6, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1));  // lw r6
        tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1));  // add r6
        tbl.push_back(mk(1, 0, 0, 0, 6, 0, 1, 0, 2, 1, 0, 1, 1));  // older load masked
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1));  // lw r0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0, 1, 1));  // r0 never matches
        tbl.push_back(mk(1, 7, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1));  // lw r7
        tbl.push_back(mk(1, 0, 0, 0, 7, 7, 0, 0, 1, 1, 0, 1, 1));  // operands unused
        tbl.push_back(mk(1, 5, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1));  // lw r5
        tbl.push_back(mk(1, 0, 0, 0, 5, 0, 1, 1, 2, 1, 0, 1, 1));  // flush over load-use
        tbl.push_back(mk(1, 0, 0, 0, 5, 7, 3, 0, 1, 1, 0, 1, 1));  // all entries gone

        foreach (tbl[r]) begin
            drive(int'(tbl[r].v), int'(tbl[r].rd), int'(tbl[r].wr), int'(tbl[r].ld),
                  int'(tbl[r].s0), int'(tbl[r].s1), int'(tbl[r].u), int'(tbl[r].fl));
            tick(1);
            $display("row %0d: fwd_sel=%h stall=%b ready=%b stall_cnt=%0d",
                     r, a_sel[1], a_stl[1], a_rdy[1], a_cnt[1]);
            chk($sformatf("row%0d_fwd_sel", r), 32'(a_sel[1]), 32'({tbl[r].e1, tbl[r].e0}));
            chk($sformatf("row%0d_stall", r), 32'(a_stl[1]), 32'(tbl[r].est));
            chk($sformatf("row%0d_ready", r), 32'(a_rdy[1]), 32'(tbl[r].erdy));
            chk($sformatf("row%0d_stall_cnt", r), a_cnt[1], tbl[r].ecnt);
        end

        // Stall-until-retire mode with the stall counter parked just below saturation.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(1);
        force dut0.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut0.stall_cnt_q;
        mcnt[0] = 32'hFFFF_FFFE;
        drive(1, 3, 1, 0, 0, 0, 0, 0);
        tick(1);
        drive(1, 0, 0, 0, 3, 0, 1, 0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (a_stl[0]) n++;
            else break;
        end
        $display("nofwd: stall cycles=%0d stall_cnt=%h", n, a_cnt[0]);
        chk("nofwd_stall_cycles", 32'(n), 32'd3);
        chk("nofwd_fwd_sel", 32'(a_sel[0]), 32'h11);
        chk("cnt_saturated", a_cnt[0], 32'hFFFF_FFFF);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        $display("after reset: stall_cnt=%0d/%0d", a_cnt[0], a_cnt[1]);
        chk("rst_cnt_nofwd", a_cnt[0], 32'd0);
        chk("rst_cnt_fwd", a_cnt[1], 32'd0);

        // Reset landing on a load-use stall leaves nothing behind.
        drive(1, 5, 1, 1, 0, 0, 0, 0);
        tick(1);
        drive(1, 0, 0, 0, 5, 0, 1, 0);
        rst_n = 1'b0;
        tick(1);
        chk("stall_in_reset_cycle", 32'(a_stl[1]), 32'd1);
        rst_n = 1'b1;
        tick(1);
        $display("reset during stall: stall=%b fwd_sel=%h", a_stl[1], a_sel[1]);
        chk("stall_after_reset", 32'(a_stl[1]), 32'd0);
        chk("sel_after_reset", 32'(a_sel[1]), 32'h11);

        for (int c = 0; c < 400; c++) begin
            drive(int'($urandom_range(3) != 0), int'($urandom_range(3)), int'($urandom_range(1)),
                  int'($urandom_range(2) == 0), int'($urandom_range(3)), int'($urandom_range(3)),
                  int'($urandom_range(3)), int'($urandom_range(24) == 0));
            rst_n = ($urandom_range(59) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- AW, 5, register address width
- NSRC, 2, source operands per instruction
- DEPTH, 3, tracked in-flight stages (entry 0 = EX, 1 = MEM, 2 = WB)
- LOAD_LAT, 1, lowest entry index at which load data can be forwarded
- FWD_EN, 1, 1 = forward, 0 = stall-until-retire mode
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock, rising edge
- rst_n, in, 1, synchronous active-low reset
- issue_valid, in, 1, instruction presented for entry to EX
- issue_ready, out, 1, instruction accepted this cycle
- issue_rd, in, AW, destination register
- issue_reg_write, in, 1, instruction writes issue_rd
- issue_is_load, in, 1, instruction is a load
- src_addr, in, NSRC*AW, packed source addresses; operand i at [i*AW +: AW]
- src_used, in, NSRC, operand i is read
- flush, in, 1, kill all in-flight entries
- fwd_sel, out, NSRC*(DEPTH+1), one-hot per operand: bit 0 = register file, bit k+1 = entry k
- stall, out, 1, issue blocked by a hazard
- stall_cnt, out, 32, saturating count of stall cycles

Function
REQ-004 The block SHALL keep a shift register of DEPTH entries, each holding {valid, rd, wr, ld}.
REQ-005 On each clock edge when not in reset, entry k SHALL move to entry k+1 and entry DEPTH-1 SHALL retire.
REQ-006 Entry 0 SHALL load {1, issue_rd, issue_reg_write, issue_is_load} when issue_valid && issue_ready; otherwise it SHALL load a bubble (valid = 0).
REQ-007 An entry k SHALL match operand i when valid && wr && rd == src addr i && rd != 0 && src_used[i].
REQ-008 For each operand, fwd_sel SHALL select the lowest-index (youngest) matching entry, else bit 0.
REQ-009 fwd_sel SHALL be combinational from the current inputs and entries; it is evaluated even when issue_valid = 0.
REQ-010 When FWD_EN = 1, hazard SHALL be asserted if the youngest match for any operand is a load (ld = 1) at index < LOAD_LAT.
REQ-011 When FWD_EN = 0, hazard SHALL be asserted on any match at any index, and fwd_sel SHALL be bit 0.
REQ-012 stall SHALL equal issue_valid && hazard, and issue_ready SHALL equal !hazard.
REQ-013 During a stall, a bubble SHALL enter entry 0, and older entries SHALL keep advancing, so the stall resolves without an external pop.
REQ-014 flush SHALL clear every entry's valid bit at the clock edge.
REQ-015 During a flush cycle, issue_ready SHALL be 1 and the issuing instruction SHALL NOT be written; entry 0 becomes a bubble.
REQ-016 stall SHALL be 0 in any cycle where flush = 1.
REQ-017 stall_cnt SHALL increment by 1 on each clock where stall = 1, and SHALL hold at 32'hFFFF_FFFF once it reaches that value.
REQ-018 Simultaneous match in several entries SHALL resolve to the youngest entry only; an older load SHALL NOT cause a stall if a younger non-load matches.
REQ-019 Register 0 SHALL never match, even with wr = 1.

Reset
REQ-020 While rst_n = 0 at a clock edge, all entries SHALL become invalid and stall_cnt SHALL become 0.
REQ-021 After reset, every fwd_sel field SHALL be one-hot bit 0, stall SHALL be 0, and issue_ready SHALL be 1.
REQ-022 Reset asserted during a stall SHALL clear the hazard on the next cycle; no pending entry survives.

Verification
REQ-023 The bench SHALL cover these scenarios (defaults; stimulus -> required response):
- ALU hazard: issue add r3; next cycle issue src0 = r3 -> fwd_sel[0] = 4'b0010, no stall.
- Distance 2: add r3, nop, then src1 = r3 -> fwd_sel[1] = 4'b0100; distance 3 -> 4'b1000; distance 4 -> 4'b0001.
- Load-use: lw r5, then src0 = r5 -> stall = 1 for exactly 1 cycle, then fwd_sel[0] = 4'b0100, stall_cnt = 1.
- Youngest wins / r0: add r4, add r4, then use r4 -> 4'b0010; writes to r0 -> always 4'b0001.
- Flush during load-use stall: lw r5, use r5, flush = 1 -> stall = 0 that cycle, and all entries are invalid next cycle.
- FWD_EN = 0: add r3, then use r3 -> stall for 3 cycles; stall_cnt preset near max saturates at 32'hFFFF_FFFF; rst_n = 0 -> stall_cnt = 0.
